// File: rtl/pulse_stretcher_if.sv
// Pulse stretcher bus: event strobe in, stretched window and status out.
// master drives pulse_in (producer side); slave is the stretcher itself.
interface pulse_stretcher_if #(
  parameter int unsigned PEND_W = 3
);
  logic              pulse_in;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle events into HIGH_CYCLES-wide level windows
// separated by at least GAP_CYCLES low cycles. Events arriving while a window or
// gap is in progress are queued in a saturating pending counter.
// Optional feature macro: PULSE_STRETCH_RETRIGGER_EN -- an event during the high
// phase restarts the window instead of being queued.
module pulse_stretcher #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_stretcher_if.slave     bus
);

  localparam int unsigned MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_q, pend_nxt;
  logic              ovf_q, ovf_nxt;
  logic              level_q, busy_q;
  logic              enq, deq;

  // Next-state, phase counter and pending-queue bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_q;
    ovf_nxt   = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.pulse_in) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end
      end

      ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (bus.pulse_in) begin
          cnt_nxt = '0;
        end else if (cnt == HIGH_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`else
        enq = bus.pulse_in;
        if (cnt == HIGH_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end

      ST_GAP: begin
        enq = bus.pulse_in;
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pend_q != '0) begin
            state_nxt = ST_HIGH;
            deq       = 1'b1;
          end else if (bus.pulse_in) begin
            // Event on the exit cycle is queued and starts the next window at once
            state_nxt = ST_HIGH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Simultaneous enqueue and dequeue cancel, even when saturated
    if (enq && deq) begin
      pend_nxt = pend_q;
    end else if (deq) begin
      pend_nxt = pend_q - PEND_W'(1);
    end else if (enq) begin
      if (pend_q == PEND_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_nxt = pend_q + PEND_W'(1);
      end
    end
  end

  // State, counters and registered outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_q  <= pend_nxt;
      ovf_q   <= ovf_nxt;
      level_q <= (state_nxt == ST_HIGH);
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2).
// Each step drives one cycle of stimulus and queues the expected outputs
// {level_out, busy, pending[1:0], overflow} seen after that clock edge.
module tb_pulse_stretcher;

  localparam int unsigned PW = 2;

  // Expected output codes: {level, busy, pending, overflow}
  localparam logic [4:0] Z  = 5'b0_0_00_0;
  localparam logic [4:0] H0 = 5'b1_1_00_0;
  localparam logic [4:0] H1 = 5'b1_1_01_0;
  localparam logic [4:0] H2 = 5'b1_1_10_0;
  localparam logic [4:0] H3 = 5'b1_1_11_0;
  localparam logic [4:0] G0 = 5'b0_1_00_0;
  localparam logic [4:0] G1 = 5'b0_1_01_0;
  localparam logic [4:0] G2 = 5'b0_1_10_0;
  localparam logic [4:0] G3 = 5'b0_1_11_0;
  localparam logic [4:0] O3 = 5'b0_1_11_1;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  pulse_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_stretcher #(
    .HIGH_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_W      (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; expectation queued on drive, checked after the edge
  task automatic step(input string tag, input logic p, input logic r, input logic [4:0] e);
    exp_t       item;
    logic [4:0] obs;
    bus.pulse_in = p;
    rst          = r;
    item.tag     = tag;
    item.exp     = e;
    sb.push_back(item);
    @(posedge clk);
    #1;
    item = sb.pop_front();
    obs  = {bus.level_out, bus.busy, bus.pending, bus.overflow};
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
    end
  endtask

  // n idle-input cycles with the same expected outputs
  task automatic hold(input string tag, input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, e);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.pulse_in = 1'b0;

    // Reset held with pulse_in toggling, then release
    step("reset", 1'b1, 1'b0, Z);
    step("reset", 1'b0, 1'b0, Z);
    step("reset", 1'b1, 1'b0, Z);
    step("reset_release", 1'b0, 1'b1, Z);

    // Single event: 4-cycle window, 2-cycle gap, back to idle
    step("single_start", 1'b1, 1'b1, H0);
    hold("single_high", H0, 3);
    hold("single_gap", G0, 2);
    hold("single_idle", Z, 2);

`ifndef PULSE_STRETCH_RETRIGGER_EN
    // Burst of three: windows back to back with exact gaps
    step("burst_p0", 1'b1, 1'b1, H0);
    step("burst_p1", 1'b1, 1'b1, H1);
    step("burst_p2", 1'b1, 1'b1, H2);
    hold("burst_w1", H2, 1);
    hold("burst_g1", G2, 2);
    hold("burst_w2", H1, 4);
    hold("burst_g2", G1, 2);
    hold("burst_w3", H0, 4);
    hold("burst_g3", G0, 2);
    hold("burst_idle", Z, 1);

    // Saturation, overflow, cancel at gap exit, then reset mid-window
    step("sat_p0", 1'b1, 1'b1, H0);
    step("sat_p1", 1'b1, 1'b1, H1);
    step("sat_p2", 1'b1, 1'b1, H2);
    step("sat_p3", 1'b1, 1'b1, H3);
    step("sat_overflow", 1'b1, 1'b1, O3);
    step("sat_ovf_clear", 1'b0, 1'b1, G3);
    step("sat_exit_cancel", 1'b1, 1'b1, H3);
    hold("sat_high", H3, 1);
    step("midwin_reset", 1'b1, 1'b0, Z);
    step("midwin_release", 1'b0, 1'b1, Z);
    hold("midwin_idle", Z, 1);

    // Gap-exit coincidence with pending=1
    step("exit1_p0", 1'b1, 1'b1, H0);
    step("exit1_p1", 1'b1, 1'b1, H1);
    hold("exit1_w1", H1, 2);
    hold("exit1_g1", G1, 2);
    step("exit1_cancel", 1'b1, 1'b1, H1);
    hold("exit1_w2", H1, 3);
    hold("exit1_g2", G1, 2);
    hold("exit1_w3", H0, 4);
    hold("exit1_g3", G0, 2);
    hold("exit1_idle", Z, 1);

    // Gap-exit coincidence with pending=0: no idle cycle, pending becomes 1
    step("exit0_p0", 1'b1, 1'b1, H0);
    hold("exit0_w1", H0, 3);
    hold("exit0_g1", G0, 2);
    step("exit0_enq", 1'b1, 1'b1, H1);
    hold("exit0_w2", H1, 3);
    hold("exit0_g2", G1, 2);
    hold("exit0_w3", H0, 1);
    step("exit0_reset", 1'b0, 1'b0, Z);
    step("exit0_release", 1'b0, 1'b1, Z);
`endif

    // Second event three cycles into a window
    step("retrig_p0", 1'b1, 1'b1, H0);
    hold("retrig_w1", H0, 2);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    step("retrig_p1", 1'b1, 1'b1, H0);
    hold("retrig_ext", H0, 3);
    hold("retrig_gap", G0, 2);
    hold("retrig_idle", Z, 1);
`else
    step("retrig_p1", 1'b1, 1'b1, H1);
    hold("retrig_g1", G1, 2);
    hold("retrig_w2", H0, 4);
    hold("retrig_g2", G0, 2);
    hold("retrig_idle", Z, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
